motor_pwm_tach: RTL
===================

MOTOR_PWM_TACH -- requirements
Module: motor_pwm_tach

Interface
REQ-001 Parameter PWM_DIV, default 196, is the number of clk cycles per PWM tick (at least 1).
REQ-002 Parameter GATE_CYCLES, default 25000000, is the tach measurement window length in clk cycles (half second at 50 MHz; at least 4).
REQ-003 Parameter SYNC_STAGES, default 2, is the tach_in synchronizer depth (at least 2).
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port pw, input, 8 bits: commanded duty from the speed controller; 0 means off, 255 means fully on.
REQ-007 Port tach_in, input, 1 bit: asynchronous tachometer pulse from the motor.
REQ-008 Port pwm_out, output, 1 bit: registered motor drive.
REQ-009 Port C, output, 8 bits: measured speed, i.e. tach rising edges per gate window, saturated.
REQ-010 Port c_valid, output, 1 bit: one-cycle strobe marking a new value on C; it is also used as the controller go pulse.

Function
REQ-011 The prescaler shall count 0..PWM_DIV-1 and assert an internal tick in the cycle it wraps to 0.
REQ-012 The PWM counter shall advance only on a tick and shall count 0..254, then wrap to 0, giving a period of 255 ticks.
REQ-013 pw shall be captured into a shadow register only on the tick where the PWM counter wraps to 0; changes to pw in mid-period shall not affect the current period.
REQ-014 pwm_out shall be registered as (PWM counter < shadow), so it lags the counter by one clk cycle.
REQ-015 Boundary cases: shadow=0 drives pwm_out low for the whole period; shadow=255 drives it high for the whole period; shadow=N gives exactly N high ticks per period.
REQ-016 tach_in shall pass through SYNC_STAGES flops; a rising edge is detected when the synced value is 1 and its previous value was 0.
REQ-017 The measurement FSM shall have two states, GATE and LATCH.
REQ-018 In GATE, the gate counter counts 0..GATE_CYCLES-1, and each detected edge increments an 8-bit edge count that saturates at 255.
REQ-019 When the gate counter reaches GATE_CYCLES-1, the FSM shall move to LATCH.
REQ-020 In LATCH (one cycle), C shall be loaded with the edge count, c_valid shall be 1 in the next cycle, the gate counter shall clear, and the FSM shall return to GATE.
REQ-021 The edge count shall restart in LATCH: it becomes 1 if an edge is detected in that same cycle, otherwise 0, so no edge is ever lost or counted twice.
REQ-022 c_valid shall be high for exactly one cycle per window, at a period of GATE_CYCLES+1 clk cycles.
REQ-023 C shall hold its value between strobes.
REQ-024 The PWM path and the tach path shall be independent; pw has no effect on the measurement logic.

Reset
REQ-025 While rst_n=0: pwm_out=0, C=0, c_valid=0, all counters=0, shadow=0, synchronizer flops=0, FSM=GATE.
REQ-026 Reset shall assert asynchronously; deassertion takes effect on the next clk edge.
REQ-027 A reset in mid-window shall discard the partial edge count and produce no c_valid.
REQ-028 A reset in mid-PWM-period shall force pwm_out low immediately.
REQ-029 After rst_n rises, the first c_valid shall occur GATE_CYCLES+1 cycles later, and the first period shall use pw as captured on the first wrap tick.

Verification
REQ-030 Duty: PWM_DIV=1, pw=64 held -> each 255-cycle period has exactly 64 high cycles; pw=0 -> never high; pw=255 -> never low after the first capture.
REQ-031 Mid-period update: pw changes from 100 to 200 at counter=50 -> that period still has 100 high ticks, and the next period has 200.
REQ-032 Counting: GATE_CYCLES=1000, 37 tach pulses 20 cycles wide spread within one window -> C=37 with a single c_valid pulse; the next window with no pulses -> C=0.
REQ-033 Saturation plus boundary edge: 300 pulses in one window -> C=255; a pulse whose synced edge lands in the LATCH cycle -> counted in the next window only.
REQ-034 Reset: rst_n pulled low at gate count 500 with 10 edges counted -> outputs go to 0 asynchronously, no strobe; after release, the first c_valid arrives 1001 cycles later with only post-reset edges counted.

Source files
------------

// File: rtl/motor_pwm_tach.sv
// Motor drive PWM with a shadowed duty register, plus a tachometer
// edge counter that reports speed once per gate window.
module motor_pwm_tach #(
   parameter int PWM_DIV     = 196,
   parameter int GATE_CYCLES = 25000000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] pw,
   input  logic       tach_in,
   output logic       pwm_out,
   output logic [7:0] C,
   output logic       c_valid
);

   localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
   localparam int GW = $clog2(GATE_CYCLES);

   typedef enum logic {GATE, LATCH} state_t;

   logic [PW-1:0]          r_pre;
   logic [7:0]             r_cnt;
   logic [7:0]             r_shadow;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic [GW-1:0]          r_gcnt;
   logic [7:0]             r_ecnt;
   state_t                 r_state;
   state_t                 w_next;
   logic                   w_tick;
   logic                   w_wrap;
   logic                   w_edge;

   assign w_tick = (r_pre == PW'(PWM_DIV - 1));
   assign w_wrap = w_tick && (r_cnt == 8'd254);
   assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre    <= '0;
         r_cnt    <= '0;
         r_shadow <= '0;
         pwm_out  <= 1'b0;
      end else begin
         r_pre <= w_tick ? '0 : r_pre + 1'b1;
         if (w_tick)
            r_cnt <= w_wrap ? 8'd0 : r_cnt + 8'd1;
         // duty only changes on a period boundary
         if (w_wrap)
            r_shadow <= pw;
         pwm_out <= (r_cnt < r_shadow);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], tach_in};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= GATE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         GATE:    if (r_gcnt == GW'(GATE_CYCLES - 1)) w_next = LATCH;
         LATCH:   w_next = GATE;
         default: w_next = GATE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gcnt  <= '0;
         r_ecnt  <= '0;
         C       <= '0;
         c_valid <= 1'b0;
      end else if (r_state == LATCH) begin
         C       <= r_ecnt;
         c_valid <= 1'b1;
         r_gcnt  <= '0;
         // an edge landing here opens the next window's count
         r_ecnt  <= {7'd0, w_edge};
      end else begin
         c_valid <= 1'b0;
         r_gcnt  <= r_gcnt + 1'b1;
         if (w_edge && (r_ecnt != 8'hFF))
            r_ecnt <= r_ecnt + 8'd1;
      end
   end

endmodule
